// File: rtl/dcache_pkg.sv
// Shared types, default geometry and the store lane-mask helper for the data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int DEF_LINES      = 4;
    localparam int DEF_LINE_BYTES = 16;

    // Bit i of the mask enables bits [8i+7:8i]; lanes are big-endian, so lane 0 is the top byte.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic byte_sel);
        return byte_sel ? (4'b1000 >> lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous word/lane write and full-line fill.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int  LINES      = DEF_LINES,
    parameter int  LINE_BYTES = DEF_LINE_BYTES,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int IDX_W      = $clog2(LINES),
    localparam int TAG_W      = 32 - IDX_W - OFF_W,
    localparam int WORDS      = LINE_BYTES / 4,
    localparam int WORD_W     = $clog2(WORDS),
    localparam int LINE_W     = 8 * LINE_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic [31:0]       rd_data,
    output logic [LINE_W-1:0] rd_line,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [3:0]        wr_mask,
    input  logic [31:0]       wr_data,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line
);

    logic [WORDS-1:0][31:0] data_arr [LINES];
    logic [TAG_W-1:0]       tag_arr  [LINES];
    logic [LINES-1:0]       valid_arr;
    logic [LINES-1:0]       dirty_arr;
    logic [31:0]            merged;

    assign rd_line  = data_arr[rd_idx];
    assign rd_data  = data_arr[rd_idx][rd_word];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_valid = valid_arr[rd_idx];
    assign rd_dirty = dirty_arr[rd_idx];

    always_comb begin
        merged = data_arr[wr_idx][wr_word];
        for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_arr[fill_idx] <= fill_line;
            tag_arr[fill_idx]  <= fill_tag;
        end else if (wr_en) begin
            data_arr[wr_idx][wr_word] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_arr <= '0;
            dirty_arr <= '0;
        end else if (fill_en) begin
            valid_arr[fill_idx] <= 1'b1;
            dirty_arr[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_arr[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache with a level req/ready line memory port.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache
    import dcache_pkg::*;
#(
    parameter int  LINES      = DEF_LINES,
    parameter int  LINE_BYTES = DEF_LINE_BYTES,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int IDX_W      = $clog2(LINES),
    localparam int TAG_W      = 32 - IDX_W - OFF_W,
    localparam int LINE_W     = 8 * LINE_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic              byte_sel,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              dhit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int WORD_W = OFF_W - 2;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  index;
    logic [WORD_W-1:0] word;
    logic [1:0]        lane;

    state_t            state;
    logic [TAG_W-1:0]  miss_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              rd_dirty;
    logic [LINE_W-1:0] rd_line;
    logic              in_compare;
    logic              hit;
    logic              miss;
    logic              wr_en;
    logic              fill_en;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [31:0]       wr_data;

    assign tag   = addr[31 -: TAG_W];
    assign index = addr[OFF_W +: IDX_W];
    assign word  = addr[2 +: WORD_W];
    assign lane  = addr[1:0];

    assign in_compare = (state == COMPARE);
    assign hit        = req && rd_valid && (rd_tag == tag);
    assign miss       = in_compare && req && !hit;
    assign dhit       = in_compare && (!req || hit);
    assign wr_en      = in_compare && hit && we;
    assign wr_data    = byte_sel ? {4{wdata[7:0]}} : wdata;

    // The fill target comes from the registered request, so a core that drops req mid-miss still installs the line.
    assign fill_en  = (state == ALLOCATE) && mem_ready;
    assign fill_idx = mem_addr[OFF_W +: IDX_W];
    assign fill_tag = mem_addr[31 -: TAG_W];

    dcache_array #(
        .LINES      (LINES),
        .LINE_BYTES (LINE_BYTES)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (index),
        .rd_word   (word),
        .rd_data   (rdata),
        .rd_line   (rd_line),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .wr_en     (wr_en),
        .wr_idx    (index),
        .wr_word   (word),
        .wr_mask   (lane_mask(lane, byte_sel)),
        .wr_data   (wr_data),
        .fill_en   (fill_en),
        .fill_idx  (fill_idx),
        .fill_tag  (fill_tag),
        .fill_line (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (miss) miss_tag <= tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= COMPARE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (miss) begin
                        mem_req <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {rd_tag, index, {OFF_W{1'b0}}};
                            mem_wdata <= rd_line;
                        end else begin
                            state    <= ALLOCATE;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag, index, {OFF_W{1'b0}}};
                        end
                    end
                end
                // mem_req stays high straight into the fill so a dirty miss costs exactly two memory latencies.
                WRITEBACK: begin
                    if (mem_ready) begin
                        state    <= ALLOCATE;
                        mem_we   <= 1'b0;
                        mem_addr <= {miss_tag, fill_idx, {OFF_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state   <= COMPARE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= COMPARE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (in_compare && hit && (hit_count != '1)) hit_count <= hit_count + 32'd1;
            if (miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, reset-abort sequence, random traffic vs. a flat-memory model.
module tb_dcache;

    localparam int LINES      = 4;
    localparam int LINE_BYTES = 16;
    localparam int LINE_W     = 128;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              req       = 1'b0;
    logic              we        = 1'b0;
    logic              byte_sel  = 1'b0;
    logic [31:0]       addr      = '0;
    logic [31:0]       wdata     = '0;
    logic [31:0]       rdata;
    logic              dhit;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcache #(.LINES(LINES), .LINE_BYTES(LINE_BYTES)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .byte_sel  (byte_sel),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .dhit      (dhit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    // Background contents of main memory; line 0x40 holds 0x11111111..0x44444444.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [31:0] line;
        logic [31:0] w;
        line = a & 32'hFFFF_FFF0;
        w    = {28'd0, a[3:2]} + 32'd1;
        if (line == 32'h40) return 32'h1111_1111 * w;
        return line ^ (32'h0101_0101 * w) ^ 32'hC0DE_0000;
    endfunction

    logic [LINE_W-1:0] mem_arr [logic [31:0]];
    logic [31:0]       arch    [logic [31:0]];

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        if (mem_arr.exists(la)) return mem_arr[la];
        for (int w = 0; w < 4; w++) l[32*w +: 32] = init_word(la + 32'(4*w));
        return l;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (arch.exists(k)) return arch[k];
        return init_word(k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main memory: a transaction starts when mem_req rises or stays high right after a completion.
    int                lmem     = 3;
    int                cnt      = 0;
    int                n_txn    = 0;
    int                unstable = 0;
    logic [31:0]       t_addr   = '0;
    logic              t_we     = 1'b0;
    logic [LINE_W-1:0] t_wdata  = '0;
    logic [31:0]       wb_addr  = '0;
    logic [LINE_W-1:0] wb_data  = '0;
    logic [31:0]       fill_addr = '0;

    always @(negedge clk) begin
        if (!mem_req) begin
            cnt = 0;
            mem_ready <= 1'b0;
        end else begin
            if (mem_ready || cnt == 0) begin
                cnt = 1;
                n_txn++;
                t_addr  = mem_addr;
                t_we    = mem_we;
                t_wdata = mem_wdata;
            end else begin
                cnt++;
                if (mem_addr !== t_addr || mem_we !== t_we || (t_we && mem_wdata !== t_wdata)) unstable++;
            end
            if (cnt >= lmem) begin
                mem_ready <= 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    wb_addr = mem_addr;
                    wb_data = mem_wdata;
                end else begin
                    mem_rdata <= mem_line(mem_addr);
                    fill_addr = mem_addr;
                end
            end else begin
                mem_ready <= 1'b0;
            end
        end
    end

    // Cache-level reference: which line each index holds, whether it is dirty, and the architectural memory image.
    logic        m_valid [LINES];
    logic [25:0] m_tag   [LINES];
    logic        m_dirty [LINES];
    int          m_hits   = 0;
    int          m_misses = 0;

    task automatic ref_clear();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic ref_access(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rd, output int exp_stall, output int exp_txn);
        int          idx;
        logic [31:0] cur;
        idx = int'(a[5:4]);
        if (m_valid[idx] && m_tag[idx] == a[31:6]) begin
            exp_stall = 0;
            exp_txn   = 0;
        end else begin
            m_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_stall = 1 + 2 * lmem;
                exp_txn   = 2;
            end else begin
                exp_stall = 1 + lmem;
                exp_txn   = 1;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[31:6];
            m_dirty[idx] = 1'b0;
        end
        m_hits++;
        if (w) begin
            cur = arch_rd(a);
            if (b) cur[31 - 8*int'(a[1:0]) -: 8] = d[7:0];
            else   cur = d;
            arch[{a[31:2], 2'b00}] = cur;
            m_dirty[idx] = 1'b1;
        end
        exp_rd = arch_rd(a);
    endtask

    // One core access: drive, wait (bounded) for dhit, finish on the completing edge.
    task automatic access(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int stall);
        req = 1'b1; we = w; byte_sel = b; addr = a; wdata = d;
        stall = 0;
        rd    = '0;
        forever begin
            @(negedge clk);
            if (dhit) begin
                rd = rdata;
                break;
            end
            stall++;
            if (stall > 60) begin
                total++;
                bad++;
                $display("FAIL access_timeout addr=%h: got no dhit after %0d cycles expected completion", a, stall);
                break;
            end
        end
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; byte_sel = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic        b;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] rd;
        int          stall;
        int          txn;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] got_rd;
    logic [31:0] e_rd;
    int          got_st;
    int          e_st;
    int          e_tx;
    int          t0;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h44, 32'h0,         1'b1, 32'h2222_2222, 4, 1};
        tbl[1] = '{1'b1, 1'b0, 32'h48, 32'hDEAD_BEEF, 1'b0, 32'h0,         0, 0};
        tbl[2] = '{1'b0, 1'b0, 32'h48, 32'h0,         1'b1, 32'hDEAD_BEEF, 0, 0};
        tbl[3] = '{1'b1, 1'b0, 32'h48, 32'h3333_3333, 1'b0, 32'h0,         0, 0};
        tbl[4] = '{1'b1, 1'b1, 32'h49, 32'h0000_00AB, 1'b0, 32'h0,         0, 0};
        tbl[5] = '{1'b0, 1'b0, 32'h48, 32'h0,         1'b1, 32'h33AB_3333, 0, 0};
        tbl[6] = '{1'b0, 1'b0, 32'h148, 32'h0,        1'b1, init_word(32'h148), 7, 2};
        ref_clear();

        #2;
        check("reset mem_req",   32'(mem_req), 32'd0);
        check("reset mem_we",    32'(mem_we), 32'd0);
        check("reset mem_addr",  mem_addr, 32'd0);
        check("reset mem_wdata0", mem_wdata[31:0], 32'd0);
        check("reset dhit idle", 32'(dhit), 32'd1);
`ifdef DCACHE_STATS_EN
        check("reset hit_count",  hit_count, 32'd0);
        check("reset miss_count", miss_count, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            lmem = 3;
            t0   = n_txn;
            ref_access(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, e_rd, e_st, e_tx);
            access(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, got_rd, got_st);
            if (tbl[i].chk) check($sformatf("vec%0d rdata", i), got_rd, tbl[i].rd);
            check($sformatf("vec%0d stall", i), 32'(got_st), 32'(tbl[i].stall));
            check($sformatf("vec%0d mem txns", i), 32'(n_txn - t0), 32'(tbl[i].txn));
            if (i == 0) check("cold fill addr", fill_addr, 32'h40);
        end
        check("evict wb addr",  wb_addr, 32'h40);
        check("evict wb word2", wb_data[95:64], 32'h33AB_3333);
        check("evict wb word0", wb_data[31:0], 32'h1111_1111);
        check("evict fill addr", fill_addr, 32'h140);

        // Reset while a fill is outstanding abandons it and invalidates every line.
        lmem = 3;
        req = 1'b1; we = 1'b0; byte_sel = 1'b0; addr = 32'h44;
        @(negedge clk);
        check("abort miss dhit", 32'(dhit), 32'd0);
        @(negedge clk);
        check("abort fill mem_req", 32'(mem_req), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort mem_req", 32'(mem_req), 32'd0);
        check("abort mem_addr", mem_addr, 32'd0);
        req = 1'b0;
        ref_clear();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        t0 = n_txn;
        ref_access(1'b0, 1'b0, 32'h44, 32'h0, e_rd, e_st, e_tx);
        access(1'b0, 1'b0, 32'h44, 32'h0, got_rd, got_st);
        check("post-reset rdata", got_rd, 32'h2222_2222);
        check("post-reset stall", 32'(got_st), 32'd4);
        check("post-reset txns",  32'(n_txn - t0), 32'd1);

        for (int i = 0; i < 200; i++) begin
            logic        w;
            logic        b;
            logic [31:0] a;
            logic [31:0] d;
            int          gap;
            lmem = $urandom_range(1, 4);
            w    = 1'($urandom_range(0, 1));
            b    = w && ($urandom_range(0, 2) == 0);
            a    = 32'($urandom_range(0, 255));
            if (!b) a[1:0] = 2'b00;
            d    = $urandom;
            t0   = n_txn;
            ref_access(w, b, a, d, e_rd, e_st, e_tx);
            access(w, b, a, d, got_rd, got_st);
            if (!w) check($sformatf("rand%0d rdata @%h", i, a), got_rd, e_rd);
            check($sformatf("rand%0d stall @%h", i, a), 32'(got_st), 32'(e_st));
            check($sformatf("rand%0d mem txns", i), 32'(n_txn - t0), 32'(e_tx));
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                @(posedge clk);
                #1;
            end
        end

        check("mem outputs held during request", 32'(unstable), 32'd0);
`ifdef DCACHE_STATS_EN
        check("hit_count",  hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
